// File: rtl/gpio.sv
// Memory-mapped GPIO port: output data, direction, synchronized inputs,
// atomic set/clear/toggle of outputs, and sticky W1C edge status.
module gpio #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [31:0]      addr_i,
  input  logic [31:0]      wdata_i,
  input  logic             we_i,
  input  logic             re_i,
  output logic [31:0]      rdata_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o
);

  typedef enum logic [2:0] {
    REG_DATA_OUT = 3'd0,
    REG_DIR      = 3'd1,
    REG_DATA_IN  = 3'd2,
    REG_OUT_SET  = 3'd3,
    REG_OUT_CLR  = 3'd4,
    REG_OUT_TGL  = 3'd5,
    REG_RISE     = 3'd6,
    REG_FALL     = 3'd7
  } reg_sel_e;

  reg_sel_e         sel;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] dir;
  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] hist_p2;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] rise_evt;
  logic [WIDTH-1:0] fall_evt;
  logic [WIDTH-1:0] rise_clr;
  logic [WIDTH-1:0] fall_clr;
  logic             unused_bits;

  assign sel         = reg_sel_e'(addr_i[4:2]);
  assign wmask       = wdata_i[WIDTH-1:0];
  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], wdata_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_out <= '0;
      dir      <= '0;
    end else if (we_i) begin
      case (sel)
        REG_DATA_OUT: data_out <= wmask;
        REG_DIR:      dir      <= wmask;
        REG_OUT_SET:  data_out <= data_out | wmask;
        REG_OUT_CLR:  data_out <= data_out & ~wmask;
        REG_OUT_TGL:  data_out <= data_out ^ wmask;
        default:      ;
      endcase
    end
  end

  // Stage p0/p1: two-flop synchronizer; stage p2: previous synchronized value
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      hist_p2 <= '0;
    end else begin
      sync_p0 <= gpio_i;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
    end
  end

  assign rise_evt = sync_p1 & ~hist_p2;
  assign fall_evt = ~sync_p1 & hist_p2;
  assign rise_clr = (we_i && sel == REG_RISE) ? wmask : '0;
  assign fall_clr = (we_i && sel == REG_FALL) ? wmask : '0;

  // A new edge overrides a simultaneous W1C on the same bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= (rise & ~rise_clr) | rise_evt;
      fall <= (fall & ~fall_clr) | fall_evt;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (re_i) begin
      case (sel)
        REG_DATA_OUT: rdata_o[WIDTH-1:0] = data_out;
        REG_DIR:      rdata_o[WIDTH-1:0] = dir;
        REG_DATA_IN:  rdata_o[WIDTH-1:0] = sync_p1;
        REG_RISE:     rdata_o[WIDTH-1:0] = rise;
        REG_FALL:     rdata_o[WIDTH-1:0] = fall;
        default:      rdata_o = '0;
      endcase
    end
  end

  assign gpio_o    = data_out;
  assign gpio_oe_o = dir;

endmodule

// File: tb/tb_gpio.sv
// Directed bench for gpio: a pin-history/register model checked every cycle,
// plus hand-computed literal expectations along the register map.
module tb_gpio;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] wdata_i = '0;
  logic        we_i = 1'b0;
  logic        re_i = 1'b0;
  logic [31:0] rdata_o;
  logic [7:0]  gpio_i = '0;
  logic [7:0]  gpio_o;
  logic [7:0]  gpio_oe_o;

  int vectors = 0;
  int miscompares = 0;

  gpio #(.WIDTH(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .addr_i(addr_i), .wdata_i(wdata_i),
    .we_i(we_i), .re_i(re_i), .rdata_o(rdata_o), .gpio_i(gpio_i),
    .gpio_o(gpio_o), .gpio_oe_o(gpio_oe_o)
  );

  initial forever #5 clk_i = ~clk_i;

  // Model: register values plus the pin values sampled at the last three edges
  logic [7:0] m_out, m_dir, m_rise, m_fall;
  logic [7:0] pin_hist [0:2];
  logic [7:0] m_w;

  assign m_w = wdata_i[7:0];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_out <= '0; m_dir <= '0; m_rise <= '0; m_fall <= '0;
      pin_hist[0] <= '0; pin_hist[1] <= '0; pin_hist[2] <= '0;
    end else begin
      pin_hist[0] <= gpio_i;
      pin_hist[1] <= pin_hist[0];
      pin_hist[2] <= pin_hist[1];
      if (we_i) begin
        case (addr_i[4:2])
          3'd0: m_out <= m_w;
          3'd1: m_dir <= m_w;
          3'd3: m_out <= m_out | m_w;
          3'd4: m_out <= m_out & ~m_w;
          3'd5: m_out <= m_out ^ m_w;
          default: ;
        endcase
      end
      m_rise <= (m_rise & ~((we_i && addr_i[4:2] == 3'd6) ? m_w : 8'h00))
                | (pin_hist[1] & ~pin_hist[2]);
      m_fall <= (m_fall & ~((we_i && addr_i[4:2] == 3'd7) ? m_w : 8'h00))
                | (~pin_hist[1] & pin_hist[2]);
    end
  end

  function automatic logic [31:0] model_rdata();
    logic [7:0] v;
    v = 8'h00;
    if (re_i) begin
      case (addr_i[4:2])
        3'd0: v = m_out;
        3'd1: v = m_dir;
        3'd2: v = pin_hist[1];
        3'd6: v = m_rise;
        3'd7: v = m_fall;
        default: v = 8'h00;
      endcase
    end
    return {24'h0, v};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    #2;
    check("model gpio_o", {24'h0, gpio_o}, {24'h0, m_out});
    check("model gpio_oe_o", {24'h0, gpio_oe_o}, {24'h0, m_dir});
    check("model rdata_o", rdata_o, model_rdata());
  end

  // Bus tasks start and end at a falling edge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr_i = a; wdata_i = d; we_i = 1'b1;
    @(posedge clk_i);
    @(negedge clk_i);
    we_i = 1'b0; wdata_i = '0;
  endtask

  task automatic bus_read(input string nm, input logic [31:0] a, input logic [31:0] exp);
    addr_i = a; re_i = 1'b1;
    #1;
    check(nm, rdata_o, exp);
    re_i = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk_i);
    check("reset gpio_o", {24'h0, gpio_o}, 32'h0);
    check("reset gpio_oe_o", {24'h0, gpio_oe_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(1);
    check("idle gpio_o", {24'h0, gpio_o}, 32'h0);
    bus_read("reset DIR", 32'h04, 32'h0);

    bus_write(32'h00, 32'hA5);
    check("write DATA_OUT", {24'h0, gpio_o}, 32'hA5);
    bus_read("read DATA_OUT", 32'h00, 32'h0000_00A5);
    bus_write(32'h04, 32'hF0);
    check("write DIR", {24'h0, gpio_oe_o}, 32'hF0);

    bus_write(32'h0C, 32'h0A);
    check("OUT_SET", {24'h0, gpio_o}, 32'hAF);
    bus_write(32'h10, 32'h81);
    check("OUT_CLR", {24'h0, gpio_o}, 32'h2E);
    bus_write(32'h14, 32'hFF);
    check("OUT_TGL", {24'h0, gpio_o}, 32'hD1);
    bus_read("read OUT_SET", 32'h0C, 32'h0);
    bus_read("read OUT_TGL", 32'h14, 32'h0);

    gpio_i = 8'h3C;
    idle(1);
    bus_read("DATA_IN one edge later", 32'h08, 32'h00);
    idle(2);
    bus_read("DATA_IN settled", 32'h08, 32'h3C);
    bus_write(32'h08, 32'hFF);
    bus_read("DATA_IN read-only", 32'h08, 32'h3C);
    bus_read("RISE from 0 to 3C", 32'h18, 32'h3C);
    bus_write(32'h18, 32'hFF);
    bus_write(32'h1C, 32'hFF);

    gpio_i = 8'h0F;
    idle(4);
    bus_read("RISE 3C to 0F", 32'h18, 32'h03);
    bus_read("FALL 3C to 0F", 32'h1C, 32'h30);
    bus_write(32'h18, 32'h01);
    bus_read("RISE W1C bit0", 32'h18, 32'h02);
    bus_write(32'h1C, 32'h00);
    bus_read("FALL W0 no change", 32'h1C, 32'h30);

    gpio_i = 8'h4F;
    idle(2);
    bus_write(32'h18, 32'h40);
    bus_read("RISE set beats clear", 32'h18, 32'h42);

    addr_i = 32'h00; wdata_i = 32'h11; we_i = 1'b1; re_i = 1'b1;
    #1;
    check("read during write", rdata_o, 32'h0000_00D1);
    @(posedge clk_i);
    @(negedge clk_i);
    we_i = 1'b0; re_i = 1'b0;
    check("write after simul read", {24'h0, gpio_o}, 32'h11);

    #3;
    rst_ni = 1'b0;
    #1;
    check("async reset gpio_o", {24'h0, gpio_o}, 32'h0);
    check("async reset gpio_oe_o", {24'h0, gpio_oe_o}, 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    idle(4);
    bus_read("RISE for pin high at reset", 32'h18, 32'h4F);
    addr_i = 32'h18; re_i = 1'b0;
    #1;
    check("re low gives zero", rdata_o, 32'h0);

    bus_write(32'hFFFF_FFE0, 32'hFFFF_FFFF);
    check("full-width write", {24'h0, gpio_o}, 32'hFF);
    bus_read("masked readback", 32'h00, 32'h0000_00FF);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
